// File: rtl/sys_bridge_pkg.sv
// rtl/sys_bridge_pkg.sv - shared constants for the processor-bus bridge
// Holds the bridge register offsets, default address windows and the mapping
// of device index onto CP0 hardware interrupt lines.
package sys_bridge_pkg;

  localparam logic [31:0] DEV_BASE_DEFAULT = 32'h0000_7F00;
  localparam logic [31:0] REG_BASE_DEFAULT = 32'h0000_7F80;

  // Bridge register offsets, indexed by PrAddr[3:2].
  typedef enum logic [1:0] {
    REG_IRQ_PEND = 2'd0,
    REG_IRQ_MASK = 2'd1,
    REG_IRQ_MODE = 2'd2,
    REG_RSVD     = 2'd3
  } reg_off_e;

  // HWInt assignment: the bridge output bus is 6 bits wide and bit k drives
  // CP0 HWInt[k+HWINT_FIRST]; device i owns bridge bit i.
  localparam int HWINT_W     = 6;
  localparam int HWINT_FIRST = 2;

  function automatic int hwint_line(input int dev);
    return dev + HWINT_FIRST;
  endfunction

endpackage

// File: rtl/sys_bridge_irq_ctrl.sv
// rtl/sys_bridge_irq_ctrl.sv - interrupt pending/mask/mode registers and HWInt generation
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   dev_irq      raw device interrupt requests
//   reg_we       write strobe for the bridge register block
//   reg_off      register offset (PrAddr[3:2])
//   reg_wd       write data, only the low NDEV bits are meaningful
//   reg_rd       combinational read data of the addressed register (pre-write)
//   hwint        registered interrupt lines, bit i = device i
module sys_bridge_irq_ctrl
  import sys_bridge_pkg::*;
#(
  parameter int NDEV = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NDEV-1:0]    dev_irq,
  input  logic               reg_we,
  input  logic [1:0]         reg_off,
  input  logic [NDEV-1:0]    reg_wd,
  output logic [31:0]        reg_rd,
  output logic [HWINT_W-1:0] hwint
);

  logic [NDEV-1:0] irq_q, pend, mask, mode;
  logic [NDEV-1:0] rise, w1c, pend_next, mask_next, mode_next;
  reg_off_e        off;

  assign off = reg_off_e'(reg_off);

  always_comb begin
    rise      = dev_irq & ~irq_q;
    w1c       = '0;
    mask_next = mask;
    mode_next = mode;
    if (reg_we) begin
      case (off)
        REG_IRQ_PEND: w1c       = reg_wd;
        REG_IRQ_MASK: mask_next = reg_wd;
        REG_IRQ_MODE: mode_next = reg_wd;
        default: ;
      endcase
    end
    // The current mode selects the rule, so a mode write only applies from
    // the following cycle. In edge mode a rise beats a simultaneous W1C.
    pend_next = (mode & (rise | (pend & ~w1c))) | (~mode & dev_irq);
  end

  always_comb begin
    reg_rd = '0;
    case (off)
      REG_IRQ_PEND: reg_rd = 32'(pend);
      REG_IRQ_MASK: reg_rd = 32'(mask);
      REG_IRQ_MODE: reg_rd = 32'(mode);
      default:      reg_rd = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= '0;
      pend  <= '0;
      mask  <= '0;
      mode  <= '0;
      hwint <= '0;
    end else begin
      irq_q <= dev_irq;
      pend  <= pend_next;
      mask  <= mask_next;
      mode  <= mode_next;
      // Uses the values being written this edge so a rise or an unmask is
      // visible on HWInt one clock later, not two.
      hwint <= HWINT_W'(pend_next & mask_next);
    end
  end

endmodule

// File: rtl/sys_bridge.sv
// rtl/sys_bridge.sv - CPU processor-bus bridge to NDEV peripherals plus IRQ block
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   PrAddr/PrWD/PrWe  CPU M-stage bus address, write data, write strobe
//   PrRD         registered read data (1-cycle latency, W-stage read-back)
//   HWInt        registered interrupt lines, bit k drives CP0 HWInt[k+2]
//   dev_addr/dev_wd/dev_we  device-side offset, write data, one-hot strobe
//   dev_rd       device read data, device i at [32i+31:32i]
//   dev_irq      raw device interrupt requests
module sys_bridge
  import sys_bridge_pkg::*;
#(
  parameter int          NDEV     = 3,
  parameter logic [31:0] DEV_BASE = DEV_BASE_DEFAULT,
  parameter logic [31:0] REG_BASE = REG_BASE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          PrAddr,
  input  logic [31:0]          PrWD,
  input  logic                 PrWe,
  output logic [31:0]          PrRD,
  output logic [HWINT_W-1:0]   HWInt,
  output logic [3:0]           dev_addr,
  output logic [31:0]          dev_wd,
  output logic [NDEV-1:0]      dev_we,
  input  logic [32*NDEV-1:0]   dev_rd,
  input  logic [NDEV-1:0]      dev_irq
);

  localparam logic [27:0] DEV_PAGE = DEV_BASE[31:4];
  localparam logic [27:0] REG_PAGE = REG_BASE[31:4];

  logic [NDEV-1:0] sel_dev;
  logic            sel_reg;
  logic [31:0]     reg_rd;
  logic [31:0]     rd_mux;

  always_comb begin
    sel_dev = '0;
    rd_mux  = '0;
    for (int i = 0; i < NDEV; i++) begin
      sel_dev[i] = (PrAddr[31:4] == DEV_PAGE + 28'(i));
      if (sel_dev[i]) rd_mux = dev_rd[32*i +: 32];
    end
    sel_reg = (PrAddr[31:4] == REG_PAGE);
    if (sel_reg) rd_mux = reg_rd;
  end

  assign dev_addr = PrAddr[3:0];
  assign dev_wd   = PrWD;
  // Strobes are held low while reset is high so no device sees a write
  // from an access that reset interrupted.
  assign dev_we   = (PrWe && !reset) ? sel_dev : '0;

  sys_bridge_irq_ctrl #(.NDEV(NDEV)) u_irq (
    .clk     (clk),
    .reset   (reset),
    .dev_irq (dev_irq),
    .reg_we  (PrWe && sel_reg),
    .reg_off (PrAddr[3:2]),
    .reg_wd  (PrWD[NDEV-1:0]),
    .reg_rd  (reg_rd),
    .hwint   (HWInt)
  );

  // Captured every cycle; register reads return the pre-write value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) PrRD <= '0;
    else       PrRD <= rd_mux;
  end

endmodule

// File: tb/tb_sys_bridge.sv
// tb/tb_sys_bridge.sv - directed self-checking bench for sys_bridge
module tb_sys_bridge;

  localparam int NDEV = 3;
  localparam logic [31:0] RB = 32'h0000_7F80;

  logic               clk = 1'b0;
  logic               reset;
  logic [31:0]        PrAddr, PrWD, PrRD;
  logic               PrWe;
  logic [5:0]         HWInt;
  logic [3:0]         dev_addr;
  logic [31:0]        dev_wd;
  logic [NDEV-1:0]    dev_we;
  logic [32*NDEV-1:0] dev_rd;
  logic [NDEV-1:0]    dev_irq;

  int errors = 0;
  int checks = 0;

  sys_bridge #(.NDEV(NDEV)) dut (
    .clk(clk), .reset(reset), .PrAddr(PrAddr), .PrWD(PrWD), .PrWe(PrWe),
    .PrRD(PrRD), .HWInt(HWInt), .dev_addr(dev_addr), .dev_wd(dev_wd),
    .dev_we(dev_we), .dev_rd(dev_rd), .dev_irq(dev_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [3:0] off, input logic [31:0] data);
    PrAddr = RB + 32'(off);
    PrWD   = data;
    PrWe   = 1'b1;
    tick();
    PrWe   = 1'b0;
    PrAddr = 32'h0000_0000;
  endtask

  task automatic reg_read(input logic [3:0] off, output logic [31:0] data);
    PrAddr = RB + 32'(off);
    PrWe   = 1'b0;
    tick();
    data   = PrRD;
    PrAddr = 32'h0000_0000;
  endtask

  typedef struct {
    logic [31:0]     addr;
    logic            we;
    logic [31:0]     wd;
    logic [NDEV-1:0] exp_we;
    logic [31:0]     exp_rd;
  } vec_t;

  vec_t vecs[9];
  logic [31:0] rd;

  initial begin
    vecs[0] = '{32'h0000_7F14, 1'b1, 32'hDEAD_BEEF, 3'b010, 32'h1234_5678};
    vecs[1] = '{32'h0000_7F18, 1'b0, 32'h0000_0000, 3'b000, 32'h1234_5678};
    vecs[2] = '{32'h0000_7F40, 1'b1, 32'h1111_1111, 3'b000, 32'h0000_0000};
    vecs[3] = '{32'h0000_7F03, 1'b1, 32'h2222_2222, 3'b001, 32'hA5A5_0000};
    vecs[4] = '{32'h0000_7F2C, 1'b1, 32'h3333_3333, 3'b100, 32'hCAFE_0002};
    vecs[5] = '{32'h0000_7F30, 1'b1, 32'h4444_4444, 3'b000, 32'h0000_0000};
    vecs[6] = '{32'h0000_7EFC, 1'b1, 32'h5555_5555, 3'b000, 32'h0000_0000};
    vecs[7] = '{32'h0000_7F84, 1'b0, 32'h0000_0000, 3'b000, 32'h0000_0000};
    vecs[8] = '{32'h0001_7F14, 1'b1, 32'h6666_6666, 3'b000, 32'h0000_0000};

    reset   = 1'b1;
    PrAddr  = 32'h0000_7F14;
    PrWD    = 32'h0;
    PrWe    = 1'b1;
    dev_irq = '0;
    dev_rd  = {32'hCAFE_0002, 32'h1234_5678, 32'hA5A5_0000};
    tick();
    tick();
    check("reset_prrd", PrRD, 32'h0);
    check("reset_hwint", 32'(HWInt), 32'h0);
    check("reset_dev_we", 32'(dev_we), 32'h0);
    PrWe   = 1'b0;
    PrAddr = 32'h0;
    reset  = 1'b0;
    tick();

    // Decode / write strobe / read data table
    for (int i = 0; i < 9; i++) begin
      PrAddr = vecs[i].addr;
      PrWe   = vecs[i].we;
      PrWD   = vecs[i].wd;
      #1;
      check($sformatf("vec%0d_dev_we", i), 32'(dev_we), 32'(vecs[i].exp_we));
      tick();
      check($sformatf("vec%0d_prrd", i), PrRD, vecs[i].exp_rd);
    end
    PrWe = 1'b0;

    // Device-side address and data pass-through
    PrAddr = 32'h0000_7F14;
    PrWD   = 32'hDEAD_BEEF;
    #1;
    check("dev_addr", 32'(dev_addr), 32'h4);
    check("dev_wd", dev_wd, 32'hDEAD_BEEF);

    // Read latency: PrRD updates only at the edge
    PrAddr = 32'h0000_7F40;
    tick();
    check("lat_pre", PrRD, 32'h0);
    PrAddr = 32'h0000_7F18;
    #1;
    check("lat_before_edge", PrRD, 32'h0);
    tick();
    check("lat_after_edge", PrRD, 32'h1234_5678);
    PrAddr = 32'h0000_7F40;
    tick();
    check("lat_unmapped", PrRD, 32'h0);

    // Level interrupt on device 0
    reg_write(4'h4, 32'h1);
    dev_irq[0] = 1'b1;
    tick();
    check("lvl_raise", 32'(HWInt), 32'h01);
    dev_irq[0] = 1'b0;
    tick();
    check("lvl_drop", 32'(HWInt), 32'h00);

    // Write and read of IRQ_MASK in the same cycle shows the old value
    reg_write(4'h4, 32'h5);
    check("mask_prewrite", PrRD, 32'h1);
    reg_read(4'h4, rd);
    check("mask_postwrite", rd, 32'h5);
    reg_write(4'hC, 32'hFFFF_FFFF);
    reg_read(4'hC, rd);
    check("rsvd_reads_zero", rd, 32'h0);
    reg_write(4'h8, 32'hFFFF_FFF8);
    reg_read(4'h8, rd);
    check("mode_upper_ignored", rd, 32'h0);

    // Edge interrupt on device 2
    reg_write(4'h8, 32'h4);
    reg_write(4'h4, 32'h4);
    dev_irq[2] = 1'b1;
    tick();
    check("edge_raise", 32'(HWInt), 32'h04);
    dev_irq[2] = 1'b0;
    tick();
    tick();
    check("edge_hold", 32'(HWInt), 32'h04);
    reg_read(4'h0, rd);
    check("edge_pend_read", rd, 32'h4);
    reg_write(4'h0, 32'h4);
    check("edge_w1c_hwint", 32'(HWInt), 32'h00);
    reg_read(4'h0, rd);
    check("edge_w1c_pend", rd, 32'h0);

    // W1C does not touch a level-mode bit
    dev_irq[0] = 1'b1;
    tick();
    reg_write(4'h0, 32'h1);
    reg_read(4'h0, rd);
    check("lvl_w1c_ignored", rd, 32'h1);
    dev_irq[0] = 1'b0;
    tick();

    // Rising edge and W1C in the same cycle: set wins
    dev_irq[2] = 1'b1;
    tick();
    dev_irq[2] = 1'b0;
    tick();
    dev_irq[2] = 1'b1;
    reg_write(4'h0, 32'h4);
    check("simul_hwint", 32'(HWInt), 32'h04);
    reg_read(4'h0, rd);
    check("simul_pend", rd, 32'h4);
    dev_irq[2] = 1'b0;
    reg_write(4'h0, 32'h4);
    check("simul_clear", 32'(HWInt), 32'h00);

    // Mask does not clear pend; unmask raises HWInt; async reset
    reg_write(4'h8, 32'h0);
    reg_write(4'h4, 32'h0);
    dev_irq[0] = 1'b1;
    tick();
    check("masked_hwint", 32'(HWInt), 32'h00);
    reg_write(4'h4, 32'h1);
    check("unmask_hwint", 32'(HWInt), 32'h01);
    reg_read(4'h4, rd);
    check("mask_before_reset", rd, 32'h1);
    PrAddr = 32'h0000_7F14;
    PrWe   = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_hwint", 32'(HWInt), 32'h0);
    check("async_rst_prrd", PrRD, 32'h0);
    check("async_rst_dev_we", 32'(dev_we), 32'h0);
    PrWe       = 1'b0;
    dev_irq[0] = 1'b0;
    tick();
    reset = 1'b0;
    reg_read(4'h4, rd);
    check("post_rst_mask", rd, 32'h0);
    reg_read(4'h8, rd);
    check("post_rst_mode", rd, 32'h0);
    reg_read(4'h0, rd);
    check("post_rst_pend", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
